// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, drives the instruction memory and
// queues {pc, instr} pairs in a 2-entry buffer for decode. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [32:0] ADDR_LIMIT = 33'h0_0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        busy,
`ifdef FETCH_PERF_CNT_EN
  output logic        fault,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`else
  output logic        fault
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fpc;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic [31:0] last_instr;
  logic [31:0] last_pc;
  logic        in_range;
  logic        redirect_ok;
  logic        pop;
  logic        push;
  logic        flush;

  // Limit compare is done in 33 bits so a limit of 2^32 covers the top word.
  assign in_range    = ({1'b0, fpc} + 33'd3) < ADDR_LIMIT;
  assign redirect_ok = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign pop         = instr_valid && instr_ready;
  assign push        = (state == FETCH) && !redirect_valid && !halt_req && in_range &&
                       ((count != 2'd2) || pop);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, HALTED: if (start) state_next = FETCH;
      FETCH: begin
        if (halt_req)                        state_next = HALTED;
        else if (!in_range && !redirect_valid) state_next = FAULT;
      end
      FAULT:   state_next = FAULT;
      default: state_next = state;
    endcase
    if (redirect_valid && !redirect_ok) state_next = FAULT;
  end

  // Entering FAULT discards whatever is still queued, just like a redirect.
  assign flush = redirect_valid || ((state_next == FAULT) && (state != FAULT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fpc        <= RESET_PC;
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= 2'd0;
      last_instr <= 32'd0;
      last_pc    <= 32'd0;
    end else begin
      state      <= state_next;
      last_instr <= instr;
      last_pc    <= instr_pc;
      if (redirect_ok && (state != FAULT)) fpc <= redirect_pc;
      else if (push)                       fpc <= fpc + 32'd4;
      if (flush) begin
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
      end else begin
        if (pop)  head <= ~head;
        if (push) tail <= ~tail;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[tail]    <= fpc;
      buf_instr[tail] <= imem_rdata;
    end
  end

  // An empty buffer keeps presenting the last head so decode never sees X.
  assign instr_valid = (count != 2'd0);
  assign instr       = instr_valid ? buf_instr[head] : last_instr;
  assign instr_pc    = instr_valid ? buf_pc[head]    : last_pc;
  assign imem_addr   = fpc;
  assign busy        = (state == FETCH);
  assign fault       = (state == FAULT);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (push) fetch_count <= fetch_count + 32'd1;
      if ((state == FETCH) && (count == 2'd2) && !pop) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a vector table for the main flow plus
// hand-written sequences for reset, halt/resume, address limit and PC wrap.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;

  logic [31:0] m_addr, m_rdata, m_instr, m_pc;
  logic        m_valid, m_busy, m_fault;
  logic [31:0] l_addr, l_rdata, l_instr, l_pc;
  logic        l_valid, l_busy, l_fault;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  logic        w_valid, w_busy, w_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] m_fcnt, m_scnt, l_fcnt, l_scnt, w_fcnt, w_scnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hDEAD_C037;
      32'h4:   return 32'h0000_0013;
      default: return 32'hA500_0000 | a;
    endcase
  endfunction

  assign m_rdata = mem_word(m_addr);
  assign l_rdata = mem_word(l_addr);
  assign w_rdata = mem_word(w_addr);

  fetch_controller dut_main (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(m_addr), .imem_rdata(m_rdata), .instr_valid(m_valid),
    .instr_ready(instr_ready), .instr(m_instr), .instr_pc(m_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(m_fcnt), .stall_count(m_scnt),
`endif
    .busy(m_busy), .fault(m_fault)
  );

  fetch_controller #(.RESET_PC(32'h0), .ADDR_LIMIT(33'h0_0000_0010)) dut_limit (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(l_addr), .imem_rdata(l_rdata), .instr_valid(l_valid),
    .instr_ready(instr_ready), .instr(l_instr), .instr_pc(l_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(l_fcnt), .stall_count(l_scnt),
`endif
    .busy(l_busy), .fault(l_fault)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .ADDR_LIMIT(33'h1_0000_0000)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(w_addr), .imem_rdata(w_rdata), .instr_valid(w_valid),
    .instr_ready(instr_ready), .instr(w_instr), .instr_pc(w_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(w_fcnt), .stall_count(w_scnt),
`endif
    .busy(w_busy), .fault(w_fault)
  );

  typedef struct {
    logic        start;
    logic        halt_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_busy;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic h, input logic rv,
                              input logic [31:0] rpc, input logic rdy,
                              input logic [31:0] addr, input logic v,
                              input logic [31:0] ins, input logic [31:0] pc,
                              input logic b, input logic f);
    vec_t t;
    t.start = s; t.halt_req = h; t.redirect_valid = rv; t.redirect_pc = rpc;
    t.instr_ready = rdy; t.exp_addr = addr; t.exp_valid = v; t.exp_instr = ins;
    t.exp_pc = pc; t.exp_busy = b; t.exp_fault = f;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and return at the next falling edge.
  task automatic apply_stimulus(input logic s, input logic h, input logic rv,
                                input logic [31:0] rpc, input logic rdy);
    start = s; halt_req = h; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b0;

    //            s  h  rv rpc    rdy addr   v  instr          pc     b  f
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h00, 0, 32'h0,          32'h0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,  1, 32'h00, 0, 32'h0,          32'h0,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h04, 1, 32'hDEAD_C037,  32'h0,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h08, 1, 32'h0000_0013,  32'h4,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0C, 1, 32'h0000_0013,  32'h4,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0C, 1, 32'h0000_0013,  32'h4,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0C, 1, 32'h0000_0013,  32'h4,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h10, 1, 32'hA500_0008,  32'h8,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h14, 1, 32'hA500_000C,  32'hC,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h14, 1, 32'hA500_000C,  32'hC,  1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h40, 1, 32'h40, 0, 32'hA500_000C,  32'hC,  1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h44, 1, 32'hA500_0040,  32'h40, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 32'h48, 1, 32'hA500_0044,  32'h44, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h42, 0, 32'h48, 0, 32'hA500_0044,  32'h44, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,  1, 32'h48, 0, 32'hA500_0044,  32'h44, 0, 1));
    vecs.push_back(mk(0, 0, 1, 32'h80, 1, 32'h48, 0, 32'hA500_0044,  32'h44, 0, 1));

    do_reset();
    check_output("reset addr",  m_addr,  32'h0);
    check_output("reset valid", m_valid, 32'h0);
    check_output("reset instr", m_instr, 32'h0);
    check_output("reset pc",    m_pc,    32'h0);
    check_output("reset busy",  m_busy,  32'h0);
    check_output("reset fault", m_fault, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].start, vecs[i].halt_req, vecs[i].redirect_valid,
                     vecs[i].redirect_pc, vecs[i].instr_ready);
      check_output($sformatf("vec%0d addr", i),  m_addr,  vecs[i].exp_addr);
      check_output($sformatf("vec%0d valid", i), m_valid, vecs[i].exp_valid);
      check_output($sformatf("vec%0d instr", i), m_instr, vecs[i].exp_instr);
      check_output($sformatf("vec%0d pc", i),    m_pc,    vecs[i].exp_pc);
      check_output($sformatf("vec%0d busy", i),  m_busy,  vecs[i].exp_busy);
      check_output($sformatf("vec%0d fault", i), m_fault, vecs[i].exp_fault);
    end

    // Reset from the sticky fault state.
    do_reset();
    check_output("midreset fault", m_fault, 32'h0);
    check_output("midreset addr",  m_addr,  32'h0);
    check_output("midreset valid", m_valid, 32'h0);
    check_output("midreset instr", m_instr, 32'h0);
    check_output("midreset wrap addr", w_addr, 32'hFFFF_FFFC);

    // Halt with a full buffer, drain, then resume at the frozen address.
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_output("halt busy0", m_busy, 32'h1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_output("bp addr", m_addr, 32'h8);
    check_output("bp pc",   m_pc,   32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check_output("halt busy",  m_busy,  32'h0);
    check_output("halt addr",  m_addr,  32'h8);
    check_output("halt valid", m_valid, 32'h1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_output("drain pc4", m_pc, 32'h4);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_output("drain empty", m_valid, 32'h0);
    check_output("drain hold pc", m_pc, 32'h4);
    check_output("drain addr", m_addr, 32'h8);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check_output("resume busy", m_busy, 32'h1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_output("resume pc",    m_pc,    32'h8);
    check_output("resume instr", m_instr, 32'hA500_0008);
    check_output("resume addr",  m_addr,  32'hC);
`ifdef FETCH_PERF_CNT_EN
    check_output("fetch_count", m_fcnt, 32'd3);
    check_output("stall_count", m_scnt, 32'd1);
`endif

    // Address limit of 0x10 and PC wrap at the top of the address space.
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check_output("limit busy", l_busy, 32'h1);
    check_output("wrap start addr", w_addr, 32'hFFFF_FFFC);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_output("limit pc0", l_pc, 32'h0);
    check_output("wrap addr", w_addr, 32'h0);
    check_output("wrap pc", w_pc, 32'hFFFF_FFFC);
    check_output("wrap instr", w_instr, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_CNT_EN
    check_output("wrap fetch_count", w_fcnt, 32'd1);
    check_output("wrap stall_count", w_scnt, 32'd0);
`endif
    for (int k = 1; k < 4; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_output($sformatf("limit pc%0d", k), l_pc, 32'(4 * k));
      check_output($sformatf("limit valid%0d", k), l_valid, 32'h1);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_output("limit fault", l_fault, 32'h1);
    check_output("limit busy0", l_busy,  32'h0);
    check_output("limit empty", l_valid, 32'h0);
    check_output("limit addr",  l_addr,  32'h10);
    check_output("limit hold pc", l_pc,  32'hC);
`ifdef FETCH_PERF_CNT_EN
    check_output("limit fetch_count", l_fcnt, 32'd4);
    check_output("limit stall_count", l_scnt, 32'd0);
`endif
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check_output("limit sticky", l_fault, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
